// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Iterative 32-bit shift-add multiplier that borrows the shared
//               ALU adder. Optional macro ALU_MUL_SEQ_EARLY_EXIT_EN ends RUN
//               once the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq (
    input  logic        clk,
    input  logic        rstN,
    input  logic        startValid,
    output logic        startReady,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic [31:0] aluIn0,
    output logic [31:0] aluIn1,
    output logic [3:0]  aluCtrl,
    input  logic [31:0] aluRes,
    output logic        resValid,
    input  logic        resReady,
    output logic [31:0] result,
    output logic        busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;
    localparam logic [3:0] c_ALU_ADD = 4'b0000;

    logic [1:0]  r_state;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;
    logic        w_last;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain after this iteration.
    assign w_last = (r_cnt == 5'd31) || (r_mplier[31:1] == 31'd0);
`else
    assign w_last = (r_cnt == 5'd31);
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state  <= c_ST_IDLE;
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_acc    <= 32'd0;
            r_cnt    <= 5'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (startValid) begin
                        r_mcand  <= opA;
                        r_mplier <= opB;
                        r_acc    <= 32'd0;
                        r_cnt    <= 5'd0;
                        r_state  <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_acc    <= aluRes;
                    r_mcand  <= {r_mcand[30:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[31:1]};
                    r_cnt    <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (resReady) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Handshake flags decode the state register only, so no path from resReady.
    assign startReady = (r_state == c_ST_IDLE);
    assign resValid   = (r_state == c_ST_DONE);
    assign busy       = (r_state == c_ST_RUN) || (r_state == c_ST_DONE);
    assign result     = r_acc;
    assign aluCtrl    = c_ALU_ADD;

    always_comb begin
        aluIn0 = 32'd0;
        aluIn1 = 32'd0;
        if (r_state == c_ST_RUN) begin
            aluIn0 = r_acc;
            aluIn1 = r_mplier[0] ? r_mcand : 32'd0;
        end
    end

endmodule
`default_nettype wire
